cache_mem_arbiter: RTL

- Shares the single physical-memory port between the instruction cache (fetch) and the data cache (mem stage).
- The arbiter grants one cache-line transaction at a time, forwards the winner's address, data and command to memory, and routes the memory response and read data back to the winner only.
- It sits between the two L1 caches and physical memory, at the top level of the datapath.

---
 rtl/cache_mem_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single physical-memory port between the instruction and data caches.
// One line transaction is granted at a time. Its command is registered, and the response is routed back to the winner only.
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter bit FAIR       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t                state;
    state_t                state_next;
    grant_t                last_grant;
    grant_t                last_grant_next;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH-1:0] cmd_addr_next;
    logic [LINE_WIDTH-1:0] cmd_wdata;
    logic [LINE_WIDTH-1:0] cmd_wdata_next;
    logic                  cmd_rd;
    logic                  cmd_rd_next;
    logic                  cmd_wr;
    logic                  cmd_wr_next;

    logic                  i_req;
    logic                  d_req;
    logic                  grant_icache;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // A tie goes to the side that did not win last time, or always to the dcache when unfair.
    function automatic logic pick_icache(input logic want_i, input logic want_d,
                                         input grant_t prev);
        logic pick;
        if (want_i && !want_d)
            pick = 1'b1;
        else if (!want_i)
            pick = 1'b0;
        else if (FAIR)
            pick = (prev == GRANT_D);
        else
            pick = 1'b0;
        return pick;
    endfunction

    assign grant_icache = pick_icache(i_req, d_req, last_grant);

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        cmd_addr_next   = cmd_addr;
        cmd_wdata_next  = cmd_wdata;
        cmd_rd_next     = cmd_rd;
        cmd_wr_next     = cmd_wr;

        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    if (grant_icache) begin
                        state_next      = SERVE_I;
                        last_grant_next = GRANT_I;
                        cmd_addr_next   = i_pmem_address;
                        cmd_wdata_next  = '0;
                        cmd_rd_next     = 1'b1;
                        cmd_wr_next     = 1'b0;
                    end else begin
                        // A simultaneous read and write from the dcache resolves to the writeback.
                        state_next      = SERVE_D;
                        last_grant_next = GRANT_D;
                        cmd_addr_next   = d_pmem_address;
                        cmd_wdata_next  = d_pmem_wdata;
                        cmd_rd_next     = d_pmem_read & ~d_pmem_write;
                        cmd_wr_next     = d_pmem_write;
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_rd     <= 1'b0;
            cmd_wr     <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            cmd_addr   <= cmd_addr_next;
            cmd_wdata  <= cmd_wdata_next;
            cmd_rd     <= cmd_rd_next;
            cmd_wr     <= cmd_wr_next;
        end
    end

    // The memory side sees only latched command state. Cache inputs may move mid-transaction.
    assign busy         = (state != IDLE);
    assign pmem_read    = busy & cmd_rd;
    assign pmem_write   = busy & cmd_wr;
    assign pmem_address = cmd_addr;
    assign pmem_wdata   = cmd_wdata;

    assign i_pmem_resp  = (state == SERVE_I) & pmem_resp;
    assign d_pmem_resp  = (state == SERVE_D) & pmem_resp;
    assign i_pmem_rdata = (state == SERVE_I) ? pmem_rdata : '0;
    assign d_pmem_rdata = (state == SERVE_D) ? pmem_rdata : '0;

endmodule
